sram_arbiter: RTL and testbench

Parametrised arbiter and timing generator for the shared 8-bit video/CPU SRAM. It replaces the fixed combinational select of CPU, screen fetch and ULAplus palette paths with N request channels. It adds two things: a fixed-priority class plus a round-robin class, and a programmable access length with registered read data. It sits between the requesters (CPU bus adapter, screen, ULAplus, DivMMC) and the va/vd/n_vrd/n_vwr pins.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/sram_arb_pick.sv | 46 ++++
 rtl/sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the video/CPU SRAM arbiter.
// State encoding and channel limits.
package sram_arbiter_pkg;

  localparam int ARB_MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } arb_state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Winner select: fixed class by lowest index,
// then round-robin class starting at rr_ptr.
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter logic [ARB_MAX_CHANNELS-1:0] RR_MASK = 8'b1100,
  parameter int PTR_W = ptr_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    rr_ptr,
  output logic [CHANNELS-1:0] win,
  output logic [PTR_W-1:0]    win_idx,
  output logic                win_rr,
  output logic                valid
);

  logic [CHANNELS-1:0] fx_req;
  logic [CHANNELS-1:0] rr_req;
  int                  j;

  always_comb begin
    fx_req  = req & ~RR_MASK[CHANNELS-1:0];
    rr_req  = req & RR_MASK[CHANNELS-1:0];
    win_idx = '0;
    valid   = 1'b0;
    j       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!valid && fx_req[i]) begin
        valid   = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!valid && rr_req[j]) begin
        valid   = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
    win    = valid ? (CHANNELS'(1) << win_idx) : '0;
    win_rr = |(win & rr_req);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shared SRAM arbiter and strobe generator.
// All pins registered; one access per ACCESS_CYCLES+2 clocks.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter logic [ARB_MAX_CHANNELS-1:0] RR_MASK = 8'b1100
) (
  input  logic                       clk28,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        req,
  input  logic [CHANNELS-1:0]        we,
  input  logic [CHANNELS*ADDR_W-1:0] addr,
  input  logic [CHANNELS*DATA_W-1:0] wdata,
  output logic [CHANNELS-1:0]        grant,
  output logic [CHANNELS-1:0]        done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          sram_a,
  output logic [DATA_W-1:0]          sram_d_o,
  output logic                       sram_d_oe,
  input  logic [DATA_W-1:0]          sram_d_i,
  output logic                       n_sram_rd,
  output logic                       n_sram_wr
);

  localparam int PTR_W = ptr_w(CHANNELS);
  localparam int CNT_W = 3;

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 8) begin : g_err_ac
    $error("sram_arbiter: ACCESS_CYCLES out of 2..8");
  end
  if (CHANNELS < 1 || CHANNELS > ARB_MAX_CHANNELS) begin : g_err_ch
    $error("sram_arbiter: CHANNELS out of 1..8");
  end
  if ((RR_MASK >> CHANNELS) != '0) begin : g_err_mask
    $error("sram_arbiter: RR_MASK wider than CHANNELS");
  end

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] ch_q, ch_d;
  logic                we_q, we_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   do_q, do_d;
  logic                oe_q, oe_d;
  logic                nrd_q, nrd_d;
  logic                nwr_q, nwr_d;

  logic [CHANNELS-1:0] win;
  logic [PTR_W-1:0]    win_idx;
  logic                win_rr;
  logic                win_vld;

  sram_arb_pick #(
    .CHANNELS (CHANNELS),
    .RR_MASK  (RR_MASK),
    .PTR_W    (PTR_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_q),
    .win     (win),
    .win_idx (win_idx),
    .win_rr  (win_rr),
    .valid   (win_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    we_d    = we_q;
    rr_d    = rr_q;
    a_d     = a_q;
    do_d    = do_q;
    rdata_d = rdata_q;
    grant_d = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
          ch_d    = win;
          we_d    = we[win_idx];
          a_d     = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          do_d    = wdata[int'(win_idx)*DATA_W +: DATA_W];
          grant_d = win;
          if (win_rr) begin
            rr_d = (win_idx == PTR_W'(CHANNELS - 1)) ?
                   '0 : win_idx + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          done_d  = ch_q;
          if (!we_q) rdata_d = sram_d_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes follow the next state so the pins stay registered.
    busy_d = (state_d != IDLE);
    oe_d   = (state_d == ACCESS) && we_d;
    nrd_d  = !((state_d == ACCESS) && !we_d);
    nwr_d  = !((state_d == ACCESS) && we_d &&
               (state_q == ACCESS));
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      we_q    <= 1'b0;
      rr_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      do_q    <= '0;
      oe_q    <= 1'b0;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sram_a    = a_q;
  assign sram_d_o  = do_q;
  assign sram_d_oe = oe_q;
  assign n_sram_rd = nrd_q;
  assign n_sram_wr = nwr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter.
// Instance a: ACCESS_CYCLES=2, instance b: ACCESS_CYCLES=3.
module tb_sram_arbiter;

  localparam int CH = 4;
  localparam int AW = 19;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [CH-1:0]    req_a, req_b, we;
  logic [CH*AW-1:0] addr;
  logic [CH*DW-1:0] wdata;
  logic [CH-1:0]    grant_a, done_a, grant_b, done_b;
  logic [DW-1:0]    rdata_a, rdata_b, sdo_a, sdo_b, sdi_a, sdi_b;
  logic [AW-1:0]    sa_a, sa_b;
  logic busy_a, busy_b, soe_a, soe_b;
  logic nrd_a, nrd_b, nwr_a, nwr_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CH-1:0] ch;
    logic [DW-1:0] rd;
  } exp_t;
  exp_t sb[$];

  // SRAM model: data is a fixed function of the address
  assign sdi_a = sa_a[7:0] ^ 8'h86;
  assign sdi_b = sa_b[7:0] ^ 8'h86;

  always #5 clk = ~clk;

  sram_arbiter #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW),
    .ACCESS_CYCLES(2), .RR_MASK(8'b0000_1100)
  ) u_a (
    .clk28(clk), .rst_n(rst_n), .req(req_a), .we(we),
    .addr(addr), .wdata(wdata), .grant(grant_a),
    .done(done_a), .rdata(rdata_a), .busy(busy_a),
    .sram_a(sa_a), .sram_d_o(sdo_a), .sram_d_oe(soe_a),
    .sram_d_i(sdi_a), .n_sram_rd(nrd_a), .n_sram_wr(nwr_a)
  );

  sram_arbiter #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW),
    .ACCESS_CYCLES(3), .RR_MASK(8'b0000_1100)
  ) u_b (
    .clk28(clk), .rst_n(rst_n), .req(req_b), .we(we),
    .addr(addr), .wdata(wdata), .grant(grant_b),
    .done(done_b), .rdata(rdata_b), .busy(busy_b),
    .sram_a(sa_b), .sram_d_o(sdo_b), .sram_d_oe(soe_b),
    .sram_d_i(sdi_b), .n_sram_rd(nrd_b), .n_sram_wr(nwr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] want;
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) tick();
    want = {4'h0, 4'h0, 8'h00, 1'b0, 19'h0, 8'h00, 1'b0, 1'b1, 1'b1};
    checks++;
    if ({grant_a, done_a, rdata_a, busy_a, sa_a, sdo_a,
         soe_a, nrd_a, nwr_a} !== want) begin
      errors++;
      $display("FAIL reset_a: got %h want %h",
        {grant_a, done_a, rdata_a, busy_a, sa_a, sdo_a,
         soe_a, nrd_a, nwr_a}, want);
    end
    checks++;
    if ({grant_b, done_b, rdata_b, busy_b, sa_b, sdo_b,
         soe_b, nrd_b, nwr_b} !== want) begin
      errors++;
      $display("FAIL reset_b: got %h want %h",
        {grant_b, done_b, rdata_b, busy_b, sa_b, sdo_b,
         soe_b, nrd_b, nwr_b}, want);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    exp_t e;
    int n, rd_cnt;
    addr[0*AW +: AW] = 19'h7C123;
    we = '0;
    sb.push_back('{ch: 4'b0001, rd: 8'hA5});
    req_a = 4'b0001;
    tick();
    checks++;
    if ({grant_a, nrd_a, sa_a} !== {4'b0001, 1'b0, 19'h7C123}) begin
      errors++;
      $display("FAIL rd_grant: got %h want %h",
        {grant_a, nrd_a, sa_a}, {4'b0001, 1'b0, 19'h7C123});
    end
    n = 1;
    rd_cnt = 1;
    while (done_a == '0 && n < 20) begin
      tick();
      n++;
      if (!nrd_a) rd_cnt++;
    end
    req_a = '0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL rd_latency: got %0d want %0d", n, 3);
    end
    checks++;
    if (rd_cnt !== 2) begin
      errors++;
      $display("FAIL rd_strobe_len: got %0d want %0d", rd_cnt, 2);
    end
    e = sb.pop_front();
    checks++;
    if ({done_a, rdata_a} !== {e.ch, e.rd}) begin
      errors++;
      $display("FAIL rd_done: got %h want %h",
        {done_a, rdata_a}, {e.ch, e.rd});
    end
    tick();
    checks++;
    if ({done_a, busy_a, grant_a} !== 9'h0) begin
      errors++;
      $display("FAIL rd_idle: got %h want %h",
        {done_a, busy_a, grant_a}, 9'h0);
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    int n, oe_cnt, wr_cnt, rd_low;
    addr[1*AW +: AW]  = 19'h00040;
    wdata[1*DW +: DW] = 8'h3C;
    we = 4'b0010;
    sb.push_back('{ch: 4'b0010, rd: 8'h00});
    req_b = 4'b0010;
    tick();
    checks++;
    if ({grant_b, soe_b, nwr_b, sa_b, sdo_b} !==
        {4'b0010, 1'b1, 1'b1, 19'h00040, 8'h3C}) begin
      errors++;
      $display("FAIL wr_setup: got %h want %h",
        {grant_b, soe_b, nwr_b, sa_b, sdo_b},
        {4'b0010, 1'b1, 1'b1, 19'h00040, 8'h3C});
    end
    n = 1;
    oe_cnt = 1;
    wr_cnt = 0;
    rd_low = 0;
    while (done_b == '0 && n < 20) begin
      tick();
      n++;
      if (soe_b) oe_cnt++;
      if (!nwr_b) wr_cnt++;
      if (!nrd_b) rd_low++;
    end
    req_b = '0;
    we = '0;
    checks++;
    if ({oe_cnt, wr_cnt, rd_low, n} !== {32'd3, 32'd2, 32'd0, 32'd4}) begin
      errors++;
      $display("FAIL wr_counts: got oe=%0d wr=%0d rd=%0d n=%0d want 3 2 0 4",
        oe_cnt, wr_cnt, rd_low, n);
    end
    checks++;
    if ({soe_b, nwr_b, nrd_b} !== 3'b011) begin
      errors++;
      $display("FAIL wr_recover: got %b want %b",
        {soe_b, nwr_b, nrd_b}, 3'b011);
    end
    e = sb.pop_front();
    checks++;
    if ({done_b, rdata_b} !== {e.ch, e.rd}) begin
      errors++;
      $display("FAIL wr_done: got %h want %h",
        {done_b, rdata_b}, {e.ch, e.rd});
    end
    tick();
  endtask

  task automatic test_priority();
    exp_t e;
    int n;
    logic [11:0] got;
    int ng;
    addr[0*AW +: AW] = 19'h00011;
    addr[2*AW +: AW] = 19'h00022;
    addr[3*AW +: AW] = 19'h00033;
    we = '0;
    sb.push_back('{ch: 4'b0001, rd: 8'h11 ^ 8'h86});
    sb.push_back('{ch: 4'b0100, rd: 8'h22 ^ 8'h86});
    sb.push_back('{ch: 4'b1000, rd: 8'h33 ^ 8'h86});
    req_a = 4'b1101;
    got = '0;
    ng = 0;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      tick();
      n++;
      if (grant_a != '0) begin
        got = {got[7:0], grant_a};
        ng++;
      end
      if (done_a != '0) begin
        e = sb.pop_front();
        checks++;
        if ({done_a, rdata_a} !== {e.ch, e.rd}) begin
          errors++;
          $display("FAIL prio_done: got %h want %h",
            {done_a, rdata_a}, {e.ch, e.rd});
        end
        req_a = req_a & ~done_a;
      end
    end
    req_a = '0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL prio_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    checks++;
    if ({ng, got} !== {32'd3, 12'h148}) begin
      errors++;
      $display("FAIL prio_order: got %0d grants %h want 3 grants 148",
        ng, got);
    end
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n, last_g, ng;
    logic [31:0] got;
    addr[2*AW +: AW] = 19'h00022;
    addr[3*AW +: AW] = 19'h00033;
    we = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        sb.push_back('{ch: 4'b0100, rd: 8'h22 ^ 8'h86});
      else
        sb.push_back('{ch: 4'b1000, rd: 8'h33 ^ 8'h86});
    end
    req_a = 4'b1100;
    got = '0;
    ng = 0;
    n = 0;
    last_g = -1;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
      if (grant_a != '0) begin
        if (last_g >= 0) begin
          checks++;
          if (n - last_g !== 4) begin
            errors++;
            $display("FAIL rr_gap: got %0d want %0d", n - last_g, 4);
          end
        end
        last_g = n;
        got = {got[27:0], grant_a};
        ng++;
      end
      if (done_a != '0) begin
        e = sb.pop_front();
        checks++;
        if ({done_a, rdata_a} !== {e.ch, e.rd}) begin
          errors++;
          $display("FAIL rr_done: got %h want %h",
            {done_a, rdata_a}, {e.ch, e.rd});
        end
        if (sb.size() == 0) req_a = '0;
      end
    end
    req_a = '0;
    checks++;
    if ({ng, got} !== {32'd8, 32'h48484848}) begin
      errors++;
      $display("FAIL rr_order: got %0d grants %h want 8 grants 48484848",
        ng, got);
      sb.delete();
    end
    repeat (2) tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: got %b want %b", busy_a, 1'b0);
    end
  endtask

  task automatic test_withdraw();
    exp_t e;
    int dones;
    addr[1*AW +: AW] = 19'h00055;
    we = '0;
    sb.push_back('{ch: 4'b0010, rd: 8'h55 ^ 8'h86});
    req_a = 4'b0010;
    tick();
    checks++;
    if (grant_a !== 4'b0010) begin
      errors++;
      $display("FAIL wd_grant: got %b want %b", grant_a, 4'b0010);
    end
    tick();
    req_a = '0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_a != '0) begin
        dones++;
        if (dones == 1) begin
          e = sb.pop_front();
          checks++;
          if ({done_a, rdata_a} !== {e.ch, e.rd}) begin
            errors++;
            $display("FAIL wd_done: got %h want %h",
              {done_a, rdata_a}, {e.ch, e.rd});
          end
        end
      end
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL wd_count: got %0d want %0d", dones, 1);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [46:0] want;
    addr[0*AW +: AW] = 19'h7C123;
    we = '0;
    req_a = 4'b0001;
    tick();
    checks++;
    if ({busy_a, nrd_a} !== 2'b10) begin
      errors++;
      $display("FAIL rm_access: got %b want %b", {busy_a, nrd_a}, 2'b10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({nrd_a, nwr_a, soe_a, busy_a, grant_a} !== {3'b110, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL rm_async: got %b want %b",
        {nrd_a, nwr_a, soe_a, busy_a, grant_a}, {3'b110, 1'b0, 4'h0});
    end
    req_a = '0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a != '0) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a != '0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rm_no_done: got %0d want %0d", dones, 0);
    end
    want = {4'h0, 4'h0, 8'h00, 1'b0, 19'h0, 8'h00, 1'b0, 1'b1, 1'b1};
    checks++;
    if ({grant_a, done_a, rdata_a, busy_a, sa_a, sdo_a,
         soe_a, nrd_a, nwr_a} !== want) begin
      errors++;
      $display("FAIL rm_reset_vals: got %h want %h",
        {grant_a, done_a, rdata_a, busy_a, sa_a, sdo_a,
         soe_a, nrd_a, nwr_a}, want);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_priority();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
